// File: rtl/stim_pkg.sv
// stim_pkg: shared encodings for the stimulus engine.
// Holds beat modes, FSM states and the default LFSR feedback mask.
package stim_pkg;

  typedef enum logic [1:0] {
    MODE_INCR   = 2'd0,
    MODE_STRIDE = 2'd1,
    MODE_LFSR   = 2'd2,
    MODE_CONST  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TMO  = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_TAPS_DEF = 32'h8020_0003;

endpackage

// File: rtl/stim_gen_if.sv
// stim_gen_if: beat stream bus (valid/ready, addr, data, last).
// master drives the beat, slave returns ready.
interface stim_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;

  modport master (
    output valid, addr, data, last,
    input  ready
  );

  modport slave (
    input  valid, addr, data, last,
    output ready
  );
endinterface

// File: rtl/stim_lfsr_step.sv
// stim_lfsr_step: one combinational Galois LFSR step.
// Ports: d (current value) -> q (next value); TAPS is the feedback mask.
module stim_lfsr_step #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = '0
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  assign q = (d >> 1) ^ (d[0] ? TAPS : '0);
endmodule

// File: rtl/stim_gen.sv
// stim_gen: programmable burst of (addr, data) beats with watchdog.
// Ports: sys_clk/sys_rst, start + config, out_if beat bus, busy/done/timeout.
module stim_gen
  import stim_pkg::*;
#(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          CNT_WIDTH      = 16,
  parameter int          TIMEOUT_CYCLES = 2500,
  parameter logic [31:0] LFSR_TAPS      = LFSR_TAPS_DEF
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] addr_base,
  input  logic [ADDR_WIDTH-1:0] addr_stride,
  input  logic [DATA_WIDTH-1:0] data_seed,
  input  logic [CNT_WIDTH-1:0]  length,
  stim_gen_if.master            out_if,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);

  localparam logic [DATA_WIDTH-1:0] TAPS_W =
    DATA_WIDTH'(LFSR_TAPS);
  localparam logic [31:0] WDG_LIM =
    32'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [31:0]           wdg_q, wdg_d;
  logic                  tmo_q, tmo_d;

  logic [DATA_WIDTH-1:0] lfsr_nxt;
  logic                  run;
  logic                  xfer;
  logic                  expire;

  stim_lfsr_step #(
    .WIDTH (DATA_WIDTH),
    .TAPS  (TAPS_W)
  ) u_lfsr (
    .d (data_q),
    .q (lfsr_nxt)
  );

  assign run    = (state_q == ST_RUN);
  assign xfer   = run && out_if.ready;
  assign expire = (TIMEOUT_CYCLES != 0) && (wdg_q == WDG_LIM);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    data_d   = data_q;
    rem_d    = rem_q;
    wdg_d    = wdg_q;
    tmo_d    = tmo_q;
    case (state_q)
      ST_RUN: begin
        wdg_d = wdg_q + 32'd1;
        if (xfer) begin
          if (rem_q == CNT_WIDTH'(1)) begin
            state_d = ST_DONE;
          end else begin
            rem_d = rem_q - CNT_WIDTH'(1);
            unique case (mode_q)
              MODE_INCR: begin
                addr_d = addr_q + ADDR_WIDTH'(1);
                data_d = data_q + DATA_WIDTH'(1);
              end
              MODE_STRIDE: begin
                addr_d = addr_q + stride_q;
                data_d = data_q + DATA_WIDTH'(1);
              end
              MODE_LFSR: begin
                addr_d = addr_q + ADDR_WIDTH'(1);
                data_d = lfsr_nxt;
              end
              MODE_CONST: ;
            endcase
          end
        end
        // Expiry wins even over a final-beat transfer.
        if (expire) begin
          state_d = ST_TMO;
          tmo_d   = 1'b1;
        end
      end
      default: begin
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (start) begin
          mode_d   = mode_e'(mode);
          addr_d   = addr_base;
          stride_d = addr_stride;
          rem_d    = length;
          wdg_d    = '0;
          tmo_d    = 1'b0;
          // All-zero is the LFSR lock-up state.
          if (mode_e'(mode) == MODE_LFSR && data_seed == '0)
            data_d = DATA_WIDTH'(1);
          else
            data_d = data_seed;
          state_d = (length == '0) ? ST_DONE : ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_INCR;
      addr_q   <= '0;
      stride_q <= '0;
      data_q   <= '0;
      rem_q    <= '0;
      wdg_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      wdg_q    <= wdg_d;
      tmo_q    <= tmo_d;
    end
  end

  assign out_if.valid = run;
  assign out_if.addr  = addr_q;
  assign out_if.data  = data_q;
  assign out_if.last  = run && (rem_q == CNT_WIDTH'(1));
  assign busy         = run;
  assign done         = (state_q == ST_DONE);
  assign timeout      = tmo_q;

endmodule

// File: tb/tb_stim_gen.sv
// tb_stim_gen: scoreboard bench for stim_gen.
// Directed bursts push expected beats; a negedge monitor checks them.
module tb_stim_gen;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start   = 1'b0;
  logic [1:0]  mode    = 2'd0;
  logic [31:0] addr_base   = '0;
  logic [31:0] addr_stride = '0;
  logic [31:0] data_seed   = '0;
  logic [15:0] length      = '0;
  logic        busy, done, timeout;

  stim_gen_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  stim_gen #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .CNT_WIDTH      (16),
    .TIMEOUT_CYCLES (10),
    .LFSR_TAPS      (32'h8020_0003)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .start       (start),
    .mode        (mode),
    .addr_base   (addr_base),
    .addr_stride (addr_stride),
    .data_seed   (data_seed),
    .length      (length),
    .out_if      (bus),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout)
  );

  logic [31:0] lf_in, lf_out;
  stim_lfsr_step #(.WIDTH(32), .TAPS(32'h8020_0003)) u_ref (
    .d (lf_in),
    .q (lf_out)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t q[$];
  int passed = 0, total = 0;
  int cyc = 0, start_cyc = 0;
  int xfer_cnt = 0, first_xfer_cyc = 0, last_xfer_cyc = 0;
  int done_cnt = 0, done_cyc = 0, exp_done = 0;
  int valid_cycles = 0;
  bit seen_busy = 0;
  int rmode = 0;

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  name, act, exp);
  endtask

  function automatic void exp_beat(logic [31:0] a,
                                   logic [31:0] d, logic l);
    beat_t b;
    b.a = a; b.d = d; b.l = l;
    q.push_back(b);
  endfunction

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  // 0: always ready, 1: toggle each cycle, 2: held low
  initial begin
    bus.ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #2;
      case (rmode)
        1:       bus.ready = ~bus.ready;
        2:       bus.ready = 1'b0;
        default: bus.ready = 1'b1;
      endcase
    end
  end

  // Monitor: every presented beat is compared to the queue head,
  // which is popped only when the beat is accepted.
  initial forever begin
    @(negedge sys_clk);
    if (bus.valid) begin
      valid_cycles++;
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_beat: addr 0x%0h data 0x%0h",
                 bus.addr, bus.data);
      end else begin
        check("beat_addr", 64'(bus.addr), 64'(q[0].a));
        check("beat_data", 64'(bus.data), 64'(q[0].d));
        check("beat_last", 64'(bus.last), 64'(q[0].l));
        if (bus.ready) begin
          void'(q.pop_front());
          xfer_cnt++;
          if (xfer_cnt == 1) first_xfer_cyc = cyc;
          last_xfer_cyc = cyc;
        end
      end
    end
    if (busy) seen_busy = 1;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic go(logic [1:0] m, logic [31:0] b, logic [31:0] s,
                    logic [31:0] sd, logic [15:0] n);
    @(posedge sys_clk);
    #1;
    mode = m; addr_base = b; addr_stride = s;
    data_seed = sd; length = n;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge sys_clk);
      #1;
      if (done_cnt == exp_done) ok = 1;
    end
    check(name, 64'(done_cnt), 64'(exp_done));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    lf_in = 32'h8020_0003;
    #1;
    check("lfsr_ref_a", 64'(lf_out), 64'hC030_0002);
    lf_in = 32'h1;
    #1;
    check("lfsr_ref_b", 64'(lf_out), 64'h8020_0003);

    #2;
    check("rst_valid", 64'(bus.valid), 0);
    check("rst_addr", 64'(bus.addr), 0);
    check("rst_data", 64'(bus.data), 0);
    check("rst_last", 64'(bus.last), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_timeout", 64'(timeout), 0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;

    // INCR, zero-bubble with ready held high
    rmode = 0; xfer_cnt = 0;
    exp_beat(32'h100, 32'h0, 1'b0);
    exp_beat(32'h101, 32'h1, 1'b0);
    exp_beat(32'h102, 32'h2, 1'b0);
    exp_beat(32'h103, 32'h3, 1'b1);
    exp_done++;
    go(2'd0, 32'h100, 32'h0, 32'h0, 16'd4);
    wait_done("incr_done", 20);
    check("incr_first_lat", 64'(first_xfer_cyc - start_cyc), 1);
    check("incr_span", 64'(last_xfer_cyc - first_xfer_cyc), 3);
    check("incr_done_lat", 64'(done_cyc - last_xfer_cyc), 1);
    check("incr_left", 64'(q.size()), 0);
    @(negedge sys_clk);
    check("incr_done_pulse", 64'(done), 0);
    check("incr_idle_valid", 64'(bus.valid), 0);

    // STRIDE with address wrap
    exp_beat(32'hFFFF_FFF8, 32'h55, 1'b0);
    exp_beat(32'hFFFF_FFFC, 32'h56, 1'b0);
    exp_beat(32'h0000_0000, 32'h57, 1'b1);
    exp_done++;
    go(2'd1, 32'hFFFF_FFF8, 32'h4, 32'h55, 16'd3);
    wait_done("stride_done", 20);
    check("stride_left", 64'(q.size()), 0);

    // LFSR, zero seed, ready toggling, ignored start mid-run
    rmode = 1;
    exp_beat(32'h200, 32'h0000_0001, 1'b0);
    exp_beat(32'h201, 32'h8020_0003, 1'b0);
    exp_beat(32'h202, 32'hC030_0002, 1'b1);
    exp_done++;
    go(2'd2, 32'h200, 32'h0, 32'h0, 16'd3);
    #1;
    mode = 2'd3; addr_base = 32'h999; length = 16'd1;
    start = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
    wait_done("lfsr_done", 20);
    check("lfsr_left", 64'(q.size()), 0);

    // zero-length burst
    rmode = 0; seen_busy = 0; valid_cycles = 0;
    exp_done++;
    go(2'd0, 32'h500, 32'h0, 32'h0, 16'd0);
    wait_done("zero_done", 5);
    check("zero_done_lat", 64'(done_cyc - start_cyc), 1);
    check("zero_busy", 64'(seen_busy), 0);
    check("zero_valid", 64'(valid_cycles), 0);

    // watchdog expiry with ready held low
    rmode = 2; bus.ready = 1'b0; valid_cycles = 0;
    exp_beat(32'h300, 32'h7, 1'b0);
    go(2'd0, 32'h300, 32'h0, 32'h7, 16'd5);
    for (int i = 0; i < 30 && !timeout; i++) @(negedge sys_clk);
    check("tmo_flag", 64'(timeout), 1);
    check("tmo_valid", 64'(bus.valid), 0);
    check("tmo_valid_cycles", 64'(valid_cycles), 10);
    repeat (3) @(negedge sys_clk);
    check("tmo_sticky", 64'(timeout), 1);
    check("tmo_no_done", 64'(done_cnt), 64'(exp_done));
    q.delete();

    rmode = 0;
    exp_beat(32'h310, 32'h20, 1'b0);
    exp_beat(32'h311, 32'h21, 1'b1);
    exp_done++;
    go(2'd0, 32'h310, 32'h0, 32'h20, 16'd2);
    check("tmo_cleared", 64'(timeout), 0);
    wait_done("after_tmo_done", 20);
    check("after_tmo_left", 64'(q.size()), 0);

    // async reset on beat 2 of 4
    xfer_cnt = 0;
    exp_beat(32'h400, 32'h10, 1'b0);
    exp_beat(32'h401, 32'h11, 1'b0);
    exp_beat(32'h402, 32'h12, 1'b0);
    exp_beat(32'h403, 32'h13, 1'b1);
    go(2'd0, 32'h400, 32'h0, 32'h10, 16'd4);
    for (int i = 0; i < 10 && xfer_cnt < 1; i++) begin
      @(negedge sys_clk);
      #1;
    end
    @(posedge sys_clk);
    #1;
    check("mid_beat2_addr", 64'(bus.addr), 64'h401);
    sys_rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(bus.valid), 0);
    check("mid_rst_addr", 64'(bus.addr), 0);
    check("mid_rst_data", 64'(bus.data), 0);
    check("mid_rst_last", 64'(bus.last), 0);
    check("mid_rst_busy", 64'(busy), 0);
    q.delete();
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("mid_rst_no_done", 64'(done_cnt), 64'(exp_done));

    exp_beat(32'h400, 32'h10, 1'b0);
    exp_beat(32'h401, 32'h11, 1'b1);
    exp_done++;
    go(2'd0, 32'h400, 32'h0, 32'h10, 16'd2);
    wait_done("post_rst_done", 20);
    check("post_rst_left", 64'(q.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
